// File: rtl/seg_scan_drv_pkg.sv
// Shared display encoding constants for the segment scan driver and the BCD-to-segment decoder.
// Both sides import this so blank/off/zero encodings always agree.
package seg_scan_drv_pkg;

    typedef logic [7:0] seg_pat_t;
    typedef logic [5:0] seg_com_t;
    typedef logic [2:0] digit_idx_t;

    localparam seg_pat_t    SEG_BLANK    = 8'h00;
    localparam seg_com_t    COM_OFF      = 6'b111111;
    localparam int unsigned N_DIGITS     = 6;
    localparam seg_pat_t    ZERO_PAT_DEF = 8'hFC;

    function automatic seg_com_t com_onecold(input digit_idx_t idx);
        com_onecold = ~(6'b000001 << idx);
    endfunction

endpackage

// File: rtl/seg_scan_drv_if.sv
// Pattern inputs, display controls and multiplexed pin outputs of the scan driver.
// The slave modport is the driver itself; master is whoever feeds it patterns.
interface seg_scan_drv_if;
    import seg_scan_drv_pkg::*;

    logic     en;
    logic     lz_en;
    logic     colon_en;
    seg_pat_t seg_d0;
    seg_pat_t seg_d1;
    seg_pat_t seg_d2;
    seg_pat_t seg_d3;
    seg_pat_t seg_d4;
    seg_pat_t seg_d5;
    seg_pat_t seg_out;
    seg_com_t seg_com;
    logic     scan_tick;

    modport slave (
        input  en, lz_en, colon_en,
        input  seg_d0, seg_d1, seg_d2, seg_d3, seg_d4, seg_d5,
        output seg_out, seg_com, scan_tick
    );

    modport master (
        output en, lz_en, colon_en,
        output seg_d0, seg_d1, seg_d2, seg_d3, seg_d4, seg_d5,
        input  seg_out, seg_com, scan_tick
    );

endinterface

// File: rtl/seg_scan_drv_scan_tick_gen.sv
// Modulo-N counter advanced by an enable pulse; o_wrap flags the increment that returns to 0.
// Produces enable pulses only, never a derived clock.
module seg_scan_drv_scan_tick_gen #(
    parameter int unsigned N = 4,
    parameter int unsigned W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_inc,
    output logic [W-1:0] o_cnt,
    output logic         o_wrap
);

    localparam logic [W-1:0] Last = W'(N - 1);

    logic [W-1:0] r_cnt;

    assign o_wrap = i_inc && (r_cnt == Last);
    assign o_cnt  = r_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (i_inc) begin
            r_cnt <= o_wrap ? '0 : r_cnt + W'(1);
        end
    end

endmodule

// File: rtl/seg_scan_drv.sv
// Time-multiplexes six segment patterns onto one shared segment bus with active-low commons,
// with per-slot blanking, hour-tens leading-zero suppression and a blinking colon on the dps.
module seg_scan_drv
    import seg_scan_drv_pkg::*;
#(
    parameter int unsigned SCAN_DIV    = 1000,
    parameter int unsigned BLANK_CYC   = 8,
    parameter int unsigned BLINK_SCANS = 100,
    parameter seg_pat_t    ZERO_PAT    = ZERO_PAT_DEF
) (
    input  logic          clk,
    input  logic          rst,
    seg_scan_drv_if.slave bus
);

    localparam int unsigned         CntW     = $clog2(SCAN_DIV);
    localparam int unsigned         ScanW    = $clog2(BLINK_SCANS) + 1;
    localparam logic [CntW-1:0]     BlankCnt = CntW'(BLANK_CYC);
    localparam digit_idx_t          LastDig  = digit_idx_t'(N_DIGITS - 1);

    logic [CntW-1:0]  w_cnt;
    logic             w_slot_wrap;
    logic             w_scan_tick;
    logic             w_blink_wrap;
    logic [ScanW-1:0] w_blink_cnt_unused;
    seg_pat_t         w_sel;
    seg_pat_t         w_pat;
    logic             w_lz;
    logic             w_drive;
    seg_pat_t         w_seg_out_d;
    seg_com_t         w_seg_com_d;

    digit_idx_t r_idx;
    seg_pat_t   r_snap;
    logic       r_phase;
    seg_pat_t   r_seg_out;
    seg_com_t   r_seg_com;

    seg_scan_drv_scan_tick_gen #(
        .N (SCAN_DIV),
        .W (CntW)
    ) u_slot_cnt (
        .clk    (clk),
        .rst    (rst),
        .i_inc  (1'b1),
        .o_cnt  (w_cnt),
        .o_wrap (w_slot_wrap)
    );

    assign w_scan_tick = w_slot_wrap && (r_idx == LastDig);

    seg_scan_drv_scan_tick_gen #(
        .N (BLINK_SCANS),
        .W (ScanW)
    ) u_blink_cnt (
        .clk    (clk),
        .rst    (rst),
        .i_inc  (w_scan_tick),
        .o_cnt  (w_blink_cnt_unused),
        .o_wrap (w_blink_wrap)
    );

    always_comb begin
        w_sel = bus.seg_d0;
        unique case (r_idx)
            3'd0:    w_sel = bus.seg_d0;
            3'd1:    w_sel = bus.seg_d1;
            3'd2:    w_sel = bus.seg_d2;
            3'd3:    w_sel = bus.seg_d3;
            3'd4:    w_sel = bus.seg_d4;
            3'd5:    w_sel = bus.seg_d5;
            default: w_sel = bus.seg_d0;
        endcase
    end

    // Leading-zero suppression keeps the commons off too, so the slot stays fully dark.
    always_comb begin
        w_pat = r_snap;
        if (bus.colon_en && (r_idx == 3'd2 || r_idx == 3'd4)) begin
            w_pat[0] = r_phase;
        end
        w_lz        = bus.lz_en && (r_idx == LastDig) && (r_snap == ZERO_PAT);
        w_drive     = bus.en && (w_cnt >= BlankCnt) && !w_lz;
        w_seg_out_d = w_drive ? w_pat : SEG_BLANK;
        w_seg_com_d = w_drive ? com_onecold(r_idx) : COM_OFF;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_idx     <= '0;
            r_snap    <= SEG_BLANK;
            r_phase   <= 1'b0;
            r_seg_out <= SEG_BLANK;
            r_seg_com <= COM_OFF;
        end else begin
            if (w_slot_wrap) begin
                r_idx <= (r_idx == LastDig) ? '0 : r_idx + 3'd1;
            end
            if (w_cnt == '0) begin
                r_snap <= w_sel;
            end
            if (w_blink_wrap) begin
                r_phase <= ~r_phase;
            end
            r_seg_out <= w_seg_out_d;
            r_seg_com <= w_seg_com_d;
        end
    end

    assign bus.seg_out   = r_seg_out;
    assign bus.seg_com   = r_seg_com;
    assign bus.scan_tick = w_scan_tick;

endmodule

// File: tb/tb_seg_scan_drv.sv
// Bench for seg_scan_drv: time-based display model checked every cycle, directed pinned points,
// a ghosting monitor and a randomised soak.
module tb_seg_scan_drv;

    localparam int unsigned SD = 10;
    localparam int unsigned BC = 2;
    localparam int unsigned BS = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic       en_r  = 1'b1;
    logic       lz_r  = 1'b0;
    logic       col_r = 1'b0;
    logic [7:0] d [6];

    seg_scan_drv_if u_if ();

    assign u_if.en       = en_r;
    assign u_if.lz_en    = lz_r;
    assign u_if.colon_en = col_r;
    assign u_if.seg_d0   = d[0];
    assign u_if.seg_d1   = d[1];
    assign u_if.seg_d2   = d[2];
    assign u_if.seg_d3   = d[3];
    assign u_if.seg_d4   = d[4];
    assign u_if.seg_d5   = d[5];

    seg_scan_drv #(
        .SCAN_DIV    (SD),
        .BLANK_CYC   (BC),
        .BLINK_SCANS (BS),
        .ZERO_PAT    (8'hFC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if.slave)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = -1;

    logic [5:0] com_tbl [6] = '{6'b111110, 6'b111101, 6'b111011,
                                6'b110111, 6'b101111, 6'b011111};

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic pin(input string name, input logic [5:0] com, input logic [7:0] out);
        chk({name, "_com"}, {2'b00, u_if.seg_com}, {2'b00, com});
        chk({name, "_out"}, u_if.seg_out, out);
    endtask

    task automatic goto_neg(input int c);
        while (cyc < c) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    // Leaves the bench just after edge c, i.e. inside the cycle whose state count is c.
    task automatic set_at(input int c);
        goto_neg(c - 1);
        @(posedge clk);
        #1;
    endtask

    // Display model: s = clock edges since reset release; slot, digit and blink phase follow
    // from plain division. Outputs seen after an edge derive from the state before it.
    int         s      = 0;
    logic [7:0] snap_m = 8'h00;
    logic [7:0] exp_out = 8'h00;
    logic [5:0] exp_com = 6'b111111;

    always @(negedge clk) begin : model
        int         cnt;
        int         idx;
        int         ph;
        logic [7:0] pat;
        if (!rst) begin
            chk("rst_out", u_if.seg_out, 8'h00);
            chk("rst_com", {2'b00, u_if.seg_com}, 8'h3F);
            chk("rst_tick", {7'b0, u_if.scan_tick}, 8'h00);
            s       = 0;
            snap_m  = 8'h00;
            exp_out = 8'h00;
            exp_com = 6'b111111;
        end else begin
            chk("model_out", u_if.seg_out, exp_out);
            chk("model_com", {2'b00, u_if.seg_com}, {2'b00, exp_com});
            cnt = s % SD;
            idx = (s / SD) % 6;
            ph  = ((s / (SD * 6)) / BS) % 2;
            chk("model_tick", {7'b0, u_if.scan_tick}, {7'b0, (cnt == SD - 1 && idx == 5)});
            pat = snap_m;
            if (col_r && (idx == 2 || idx == 4)) pat[0] = ph[0];
            if (!en_r || cnt < BC || (lz_r && idx == 5 && snap_m == 8'hFC)) begin
                exp_out = 8'h00;
                exp_com = 6'b111111;
            end else begin
                exp_out = pat;
                exp_com = com_tbl[idx];
            end
            if (cnt == 0) snap_m = d[idx];
            s++;
        end
    end

    int blank_run = 0;
    int last_dig  = -1;

    always @(negedge clk) begin : ghost
        int zeros;
        int dig;
        zeros = 0;
        dig   = -1;
        for (int i = 0; i < 6; i++) begin
            if (!u_if.seg_com[i]) begin
                zeros++;
                dig = i;
            end
        end
        n_chk++;
        if (zeros > 1) begin
            n_fail++;
            $display("FAIL onecold: %0d commons low, at most 1 allowed (t=%0t)", zeros, $time);
        end
        if (zeros == 0) begin
            blank_run++;
        end else if (zeros == 1) begin
            if (dig != last_dig) begin
                n_chk++;
                if (blank_run < BC) begin
                    n_fail++;
                    $display("FAIL blank_gap: digit %0d after %0d blank cycles, need %0d (t=%0t)",
                             dig, blank_run, BC, $time);
                end
                last_dig = dig;
            end
            blank_run = 0;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        d[0] = 8'h60; d[1] = 8'hDA; d[2] = 8'hF2;
        d[3] = 8'h66; d[4] = 8'hB6; d[5] = 8'hBE;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        cyc = -1;

        goto_neg(0);  pin("c0", 6'b111111, 8'h00);
        goto_neg(2);  pin("c2", 6'b111111, 8'h00);
        goto_neg(3);  pin("c3", 6'b111110, 8'h60);
        goto_neg(10); pin("c10", 6'b111110, 8'h60);
        goto_neg(11); pin("c11", 6'b111111, 8'h00);
        goto_neg(13); pin("c13", 6'b111101, 8'hDA);

        set_at(15); d[1] = 8'h0E;
        goto_neg(16); pin("snap16", 6'b111101, 8'hDA);
        goto_neg(20); pin("snap20", 6'b111101, 8'hDA);

        goto_neg(58); chk("tick58", {7'b0, u_if.scan_tick}, 8'h00);
        goto_neg(59); chk("tick59", {7'b0, u_if.scan_tick}, 8'h01);
        goto_neg(63); pin("ret63", 6'b111110, 8'h60);
        goto_neg(73); pin("snap73", 6'b111101, 8'h0E);

        set_at(80); d[5] = 8'hFC; lz_r = 1'b1;
        goto_neg(113); pin("lz113", 6'b111111, 8'h00);
        goto_neg(118); pin("lz118", 6'b111111, 8'h00);
        set_at(140); lz_r = 1'b0;
        goto_neg(175); pin("nolz175", 6'b011111, 8'hFC);

        set_at(180); col_r = 1'b1;
        goto_neg(205); pin("col205", 6'b111011, 8'hF3);
        goto_neg(215); pin("dig3_215", 6'b110111, 8'h66);
        goto_neg(225); pin("col225", 6'b101111, 8'hB7);
        goto_neg(265); pin("col265", 6'b111011, 8'hF2);
        goto_neg(325); pin("col325", 6'b111011, 8'hF2);
        goto_neg(385); pin("col385", 6'b111011, 8'hF3);

        set_at(396); en_r = 1'b0;
        goto_neg(396); pin("en396", 6'b110111, 8'h66);
        goto_neg(397); pin("en397", 6'b111111, 8'h00);
        goto_neg(403); pin("en403", 6'b111111, 8'h00);
        set_at(404); en_r = 1'b1;
        goto_neg(404); pin("en404", 6'b111111, 8'h00);
        @(posedge clk);
        #1;
        pin("en405", 6'b101111, 8'hB7);
        rst = 1'b0;
        #1;
        pin("arst", 6'b111111, 8'h00);
        chk("arst_tick", {7'b0, u_if.scan_tick}, 8'h00);
        @(posedge clk);
        #1 rst = 1'b1;
        cyc = -1;
        goto_neg(0); pin("rr0", 6'b111111, 8'h00);
        goto_neg(2); pin("rr2", 6'b111111, 8'h00);
        goto_neg(3); pin("rr3", 6'b111110, 8'h60);

        repeat (10000) begin
            @(posedge clk);
            #1;
            en_r = ($urandom_range(0, 15) != 0);
            if ($urandom_range(0, 63) == 0) lz_r = ~lz_r;
            if ($urandom_range(0, 63) == 0) col_r = ~col_r;
            if ($urandom_range(0, 19) == 0) d[$urandom_range(0, 5)] = 8'($urandom);
            if ($urandom_range(0, 49) == 0) d[5] = 8'hFC;
        end

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
